ysyx_23060201_idu_pipe: RTL and testbench
=========================================

# ysyx_23060201_idu_pipe

Registered, parametrised instruction-decode stage for the NPC pipeline, placed between IFU and EXU. It accepts one instruction per cycle over a valid/ready handshake and holds it in a one-entry stage register. It decodes the immediate, register fields and read/write enables, and flags illegal and system instructions as data outputs rather than calling DPI. A per-register pending-write scoreboard holds issue while a source register, or a saturated destination register, has writes outstanding; writeback clears it.

## Interface
Parameters:
- XLEN, 32: data/PC width; immediates sign-extended to XLEN.
- NR_REG, 32: GPR count, 32 or 16 (RV32E); with 16, any used register address ≥16 is illegal.
- PEND_W, 2: width of each per-register pending counter; max outstanding writers per register = 2^PEND_W−1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- flush  in  1  discard stage-register contents.
- in_valid  in  1  IFU has an instruction.
- in_ready  out  1  stage can accept.
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  its PC.
- out_valid  out  1  decoded instruction ready to issue.
- out_ready  in  1  EXU accepts.
- out_pc  out  XLEN  registered PC.
- out_imm  out  XLEN  selected immediate.
- out_op  out  7  opcode.
- out_rd  out  5  destination register.
- out_func3  out  3  func3, forced 0 for lui/auipc/jal.
- out_func7  out  7  inst[31:25].
- out_raddr1, out_raddr2  out  5 each  rs1 and rs2 addresses.
- out_ren  out  2  bit0 reads rs1, bit1 reads rs2.
- out_wen  out  1  writes rd; set only when rd≠0.
- out_illegal  out  1  unknown opcode or register out of range.
- out_ecall, out_ebreak  out  1 each  exact match 0x00000073 / 0x00100073.
- wb_valid  in  1  writeback retires a write.
- wb_rd  in  5  register written.

## Operation
- Opcode classes, given as ren / wen / imm:
  - R 0110011: 11 / 1 / none (imm 0).
  - I 0010011: 01 / 1 / I.
  - load 0000011: 01 / 1 / I.
  - S 0100011: 11 / 0 / S.
  - B 1100011: 11 / 0 / B.
  - lui 0110111: 00 / 1 / U.
  - auipc 0010111: 00 / 1 / U.
  - jal 1101111: 00 / 1 / J.
  - jalr 1100111: 01 / 1 / I.
  - system 1110011: 00 / 0 / I.
  - Any other opcode: illegal, ren 00, wen 0, imm 0.
- Immediates follow the standard RV32 I/S/B/U/J bit layouts and are sign-extended to XLEN.
- Decode runs at capture time; the stage register holds the decoded fields.
- Scoreboard: NR_REG counters of PEND_W bits; register 0 is never tracked.
  - Issue (out_valid & out_ready) with out_wen: increment cnt[rd].
  - wb_valid with wb_rd≠0: decrement cnt[wb_rd].
  - Increment and decrement of the same register in one cycle: net 0.
  - Decrement at 0 is ignored and does not underflow.
- Hazard, evaluated on registered counters only (no writeback bypass):
  - (ren[0] & rs1≠0 & cnt[rs1]≠0), or
  - (ren[1] & rs2≠0 & cnt[rs2]≠0), or
  - (wen & cnt[rd]==max).
- Illegal instructions issue with out_illegal=1, forced wen=0 and ren=00, and never touch the scoreboard.

## Timing
- Reset: stage-valid 0, all outputs 0, all counters 0; in_ready=1 in the first cycle after reset deasserts.
- out_valid = stage_valid & ~hazard.
- in_ready = ~stage_valid | (out_valid & out_ready); full throughput is 1 instruction/cycle.
- Latency: an instruction accepted at edge N is presented at edge N+1 if there is no hazard.
- Output fields are stable while out_valid=1 and out_ready=0.
- A writeback at edge N clears a hazard, so out_valid can rise at edge N+1, never in the same cycle as the writeback.
- flush=1: stage-valid clears at the next edge and any same-cycle in_valid is dropped (in_ready still reads 0 during flush). Counters are unaffected. flush has priority over accept.
- Reset mid-operation discards the stage and zeroes all counters, with no drain.

## Test plan
- After reset, feed `addi x1,x0,5` (0x00500093) with out_ready=1 → next cycle out_valid=1, imm=5, rd=1, ren=01, wen=1; cnt[1]=1.
- `addi x1` then `add x2,x1,x1` (0x00108133) → add held (out_valid=0) until wb_valid, wb_rd=1; out_valid rises 1 cycle after the writeback.
- Three consecutive writes to x3 with no writeback, PEND_W=2 → third issues (cnt=3); a fourth write to x3 stalls until wb_rd=3.
- `jal x0,-4` (0xFFDFF06F) → imm=0xFFFFFFFC, func3=0, wen=0 (rd=0); `ebreak` 0x00100073 → out_ebreak=1, no stall.
- NR_REG=16, `add x17,x1,x2` → out_illegal=1, wen=0, scoreboard unchanged; opcode 0x7F → illegal.
- out_ready=0 with back-to-back input → in_ready=0 and fields stable; then flush=1 with in_valid=1 → next cycle out_valid=0 and the new instruction is dropped.

Source files
------------

// File: rtl/ysyx_23060201_idu_pipe.sv
// Decode stage: one-entry register between IFU and EXU, 1-cycle latency, up to one instruction/cycle.
// Issue stalls on a pending-write scoreboard hazard; in_ready drops while stalled or flushing.
module ysyx_23060201_idu_pipe #(
  parameter int XLEN   = 32,
  parameter int NR_REG = 32,
  parameter int PEND_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [6:0]      out_op,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_func3,
  output logic [6:0]      out_func7,
  output logic [4:0]      out_raddr1,
  output logic [4:0]      out_raddr2,
  output logic [1:0]      out_ren,
  output logic            out_wen,
  output logic            out_illegal,
  output logic            out_ecall,
  output logic            out_ebreak,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd
);
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;
  localparam logic [5:0] REG_LIM  = 6'(NR_REG);

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [6:0]      op;
    logic [4:0]      rd;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [1:0]      ren;
    logic            wen;
    logic            illegal;
    logic            ecall;
    logic            ebreak;
  } stage_t;

  stage_t            stage_q, stage_d, dec_s;
  logic              stage_vld_q, stage_vld_d;
  logic [PEND_W-1:0] cnt_q [NR_REG];
  logic [PEND_W-1:0] cnt_d [NR_REG];
  logic [PEND_W-1:0] cnt_rs1, cnt_rs2, cnt_rd;
  logic              hazard, issue, sb_inc, sb_dec;
  imm_sel_e          imm_sel;
  logic [1:0]        ren_cls;
  logic              wen_cls, bad_op, bad_reg;

  always_comb begin
    imm_sel = IMM_NONE;
    ren_cls = 2'b00;
    wen_cls = 1'b0;
    bad_op  = 1'b0;
    case (in_inst[6:0])
      OP_R:                 begin ren_cls = 2'b11; wen_cls = 1'b1; end
      OP_I, OP_LD, OP_JALR: begin ren_cls = 2'b01; wen_cls = 1'b1; imm_sel = IMM_I; end
      OP_S:                 begin ren_cls = 2'b11; imm_sel = IMM_S; end
      OP_B:                 begin ren_cls = 2'b11; imm_sel = IMM_B; end
      OP_LUI, OP_AUIPC:     begin wen_cls = 1'b1; imm_sel = IMM_U; end
      OP_JAL:               begin wen_cls = 1'b1; imm_sel = IMM_J; end
      OP_SYS:               imm_sel = IMM_I;
      default:              bad_op = 1'b1;
    endcase
    // With NR_REG=32 the limit is unreachable, so this only bites for RV32E.
    bad_reg = (ren_cls[0] & ({1'b0, in_inst[19:15]} >= REG_LIM))
            | (ren_cls[1] & ({1'b0, in_inst[24:20]} >= REG_LIM))
            | (wen_cls    & ({1'b0, in_inst[11:7]}  >= REG_LIM));

    dec_s         = '0;
    dec_s.pc      = in_pc;
    dec_s.op      = in_inst[6:0];
    dec_s.rd      = in_inst[11:7];
    dec_s.rs1     = in_inst[19:15];
    dec_s.rs2     = in_inst[24:20];
    dec_s.func7   = in_inst[31:25];
    dec_s.func3   = (in_inst[6:0] == OP_LUI || in_inst[6:0] == OP_AUIPC || in_inst[6:0] == OP_JAL)
                    ? 3'b000 : in_inst[14:12];
    dec_s.illegal = bad_op | bad_reg;
    dec_s.ren     = dec_s.illegal ? 2'b00 : ren_cls;
    dec_s.wen     = wen_cls & ~dec_s.illegal & (in_inst[11:7] != 5'd0);
    dec_s.ecall   = (in_inst == 32'h0000_0073);
    dec_s.ebreak  = (in_inst == 32'h0010_0073);
    case (imm_sel)
      IMM_I:   dec_s.imm = XLEN'($signed(in_inst[31:20]));
      IMM_S:   dec_s.imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
      IMM_B:   dec_s.imm = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
      IMM_U:   dec_s.imm = XLEN'($signed({in_inst[31:12], 12'h000}));
      IMM_J:   dec_s.imm = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
      default: dec_s.imm = '0;
    endcase
  end

  // Register 0 and addresses beyond NR_REG read as never pending.
  always_comb begin
    cnt_rs1 = '0;
    cnt_rs2 = '0;
    cnt_rd  = '0;
    for (int r = 1; r < NR_REG; r++) begin
      if (stage_q.rs1 == 5'(r)) cnt_rs1 = cnt_q[r];
      if (stage_q.rs2 == 5'(r)) cnt_rs2 = cnt_q[r];
      if (stage_q.rd  == 5'(r)) cnt_rd  = cnt_q[r];
    end
    hazard    = (stage_q.ren[0] & (cnt_rs1 != '0))
              | (stage_q.ren[1] & (cnt_rs2 != '0))
              | (stage_q.wen & (&cnt_rd));
    out_valid = stage_vld_q & ~hazard;
    issue     = out_valid & out_ready;
    in_ready  = ~flush & (~stage_vld_q | issue);
  end

  always_comb begin
    stage_vld_d = stage_vld_q;
    stage_d     = stage_q;
    if (flush) begin
      stage_vld_d = 1'b0;
    end else if (in_valid & in_ready) begin
      stage_vld_d = 1'b1;
      stage_d     = dec_s;
    end else if (issue) begin
      stage_vld_d = 1'b0;
    end

    sb_inc   = 1'b0;
    sb_dec   = 1'b0;
    cnt_d[0] = '0;
    for (int r = 1; r < NR_REG; r++) begin
      cnt_d[r] = cnt_q[r];
      sb_inc   = issue & stage_q.wen & (stage_q.rd == 5'(r));
      sb_dec   = wb_valid & (wb_rd == 5'(r)) & (cnt_q[r] != '0);
      if (sb_inc & ~sb_dec)      cnt_d[r] = cnt_q[r] + PEND_W'(1);
      else if (sb_dec & ~sb_inc) cnt_d[r] = cnt_q[r] - PEND_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_vld_q <= 1'b0;
      stage_q     <= '0;
      cnt_q       <= '{default: '0};
    end else begin
      stage_vld_q <= stage_vld_d;
      stage_q     <= stage_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_pc      = stage_q.pc;
  assign out_imm     = stage_q.imm;
  assign out_op      = stage_q.op;
  assign out_rd      = stage_q.rd;
  assign out_func3   = stage_q.func3;
  assign out_func7   = stage_q.func7;
  assign out_raddr1  = stage_q.rs1;
  assign out_raddr2  = stage_q.rs2;
  assign out_ren     = stage_q.ren;
  assign out_wen     = stage_q.wen;
  assign out_illegal = stage_q.illegal;
  assign out_ecall   = stage_q.ecall;
  assign out_ebreak  = stage_q.ebreak;
endmodule

// File: tb/tb_ysyx_23060201_idu_pipe.sv
// Scoreboarded random bench for the decode stage, plus directed RV32E and mid-run reset checks.
module tb_ysyx_23060201_idu_pipe;
  localparam int MAXP = 3;
  localparam int NDIR = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, wb_valid;
  logic [31:0] in_inst, in_pc, out_pc, out_imm;
  logic [6:0]  out_op, out_func7;
  logic [4:0]  out_rd, out_raddr1, out_raddr2, wb_rd;
  logic [2:0]  out_func3;
  logic [1:0]  out_ren;
  logic        out_wen, out_illegal, out_ecall, out_ebreak;

  logic        e_flush, e_in_valid, e_in_ready, e_out_valid, e_out_ready, e_wb_valid;
  logic [31:0] e_in_inst, e_in_pc, e_out_pc, e_out_imm;
  logic [6:0]  e_out_op, e_out_func7;
  logic [4:0]  e_out_rd, e_out_raddr1, e_out_raddr2, e_wb_rd;
  logic [2:0]  e_out_func3;
  logic [1:0]  e_out_ren;
  logic        e_out_wen, e_out_illegal, e_out_ecall, e_out_ebreak;

  ysyx_23060201_idu_pipe dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_imm(out_imm), .out_op(out_op), .out_rd(out_rd),
    .out_func3(out_func3), .out_func7(out_func7), .out_raddr1(out_raddr1),
    .out_raddr2(out_raddr2), .out_ren(out_ren), .out_wen(out_wen),
    .out_illegal(out_illegal), .out_ecall(out_ecall), .out_ebreak(out_ebreak),
    .wb_valid(wb_valid), .wb_rd(wb_rd)
  );

  ysyx_23060201_idu_pipe #(.NR_REG(16)) e_dut (
    .clk(clk), .rst_n(rst_n), .flush(e_flush), .in_valid(e_in_valid), .in_ready(e_in_ready),
    .in_inst(e_in_inst), .in_pc(e_in_pc), .out_valid(e_out_valid), .out_ready(e_out_ready),
    .out_pc(e_out_pc), .out_imm(e_out_imm), .out_op(e_out_op), .out_rd(e_out_rd),
    .out_func3(e_out_func3), .out_func7(e_out_func7), .out_raddr1(e_out_raddr1),
    .out_raddr2(e_out_raddr2), .out_ren(e_out_ren), .out_wen(e_out_wen),
    .out_illegal(e_out_illegal), .out_ecall(e_out_ecall), .out_ebreak(e_out_ebreak),
    .wb_valid(e_wb_valid), .wb_rd(e_wb_rd)
  );

  typedef struct {
    logic [31:0] pc, imm;
    logic [6:0]  op, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [1:0]  ren;
    logic        wen, ill, ecall, ebreak;
  } exp_t;

  int          errors = 0;
  int          checks = 0;
  exp_t        exp_q[$];
  int          pend[32];
  bit          stage_full, mon_en, hold;
  int          dir_idx;
  logic [31:0] cur_inst, cur_pc;

  logic [31:0] dir_list [NDIR] = '{
    32'h00500093, 32'h00108133, 32'h00100193, 32'h00200193, 32'h00300193, 32'h00400193,
    32'hFFDFF06F, 32'h00100073, 32'h00000073, 32'h0000007F, 32'h12345237, 32'hFE20AE23,
    32'hFE208EE3, 32'h80000217
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_decode(input logic [31:0] inst, input logic [31:0] pc, input int nreg);
    exp_t e;
    int   s;
    bit   wcls, ill;
    s = int'(inst);
    e.pc = pc; e.op = inst[6:0]; e.rd = inst[11:7]; e.rs1 = inst[19:15]; e.rs2 = inst[24:20];
    e.f7 = inst[31:25]; e.imm = 32'h0; e.ren = 2'b00; wcls = 0; ill = 0;
    case (inst[6:0])
      7'h33:               begin e.ren = 2'b11; wcls = 1; end
      7'h13, 7'h03, 7'h67: begin e.ren = 2'b01; wcls = 1; e.imm = s >>> 20; end
      7'h23: begin e.ren = 2'b11; e.imm = (s >>> 25) * 32 + int'(inst[11:7]); end
      7'h63: begin
        e.ren = 2'b11;
        e.imm = (s >>> 31) * 4096 + int'(inst[7]) * 2048 + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2;
      end
      7'h37, 7'h17: begin wcls = 1; e.imm = inst & 32'hFFFF_F000; end
      7'h6F: begin
        wcls = 1;
        e.imm = (s >>> 31) * 1048576 + int'(inst[19:12]) * 4096 + int'(inst[20]) * 2048 + int'(inst[30:21]) * 2;
      end
      7'h73:   e.imm = s >>> 20;
      default: ill = 1;
    endcase
    if ((e.ren[0] && int'(e.rs1) >= nreg) || (e.ren[1] && int'(e.rs2) >= nreg) || (wcls && int'(e.rd) >= nreg))
      ill = 1;
    if (ill) e.ren = 2'b00;
    e.ill    = ill;
    e.wen    = wcls && !ill && (e.rd != 5'd0);
    e.f3     = (inst[6:0] == 7'h37 || inst[6:0] == 7'h17 || inst[6:0] == 7'h6F) ? 3'd0 : inst[14:12];
    e.ecall  = (inst == 32'h0000_0073);
    e.ebreak = (inst == 32'h0010_0073);
    return e;
  endfunction

  function automatic bit hazard(input exp_t e);
    return (e.ren[0] && e.rs1 != 0 && pend[e.rs1] > 0) ||
           (e.ren[1] && e.rs2 != 0 && pend[e.rs2] > 0) ||
           (e.wen && pend[e.rd] >= MAXP);
  endfunction

  function automatic bit pend_any();
    for (int r = 0; r < 32; r++) if (pend[r] != 0) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops [12] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h73, 7'h7F, 7'h0B};
    logic [31:0] w;
    w = $urandom;
    w[6:0]   = ops[$urandom_range(0, 11)];
    w[11:7]  = 5'($urandom_range(0, 5));
    w[19:15] = 5'($urandom_range(0, 5));
    w[24:20] = 5'($urandom_range(0, 5));
    if ($urandom_range(0, 15) == 0) w = ($urandom_range(0, 1) != 0) ? 32'h0010_0073 : 32'h0000_0073;
    return w;
  endfunction

  task automatic cmp_fields(input exp_t e);
    check("pc", out_pc, e.pc);
    check("imm", out_imm, e.imm);
    check("op", 32'(out_op), 32'(e.op));
    check("rd", 32'(out_rd), 32'(e.rd));
    check("func3", 32'(out_func3), 32'(e.f3));
    check("func7", 32'(out_func7), 32'(e.f7));
    check("raddr1", 32'(out_raddr1), 32'(e.rs1));
    check("raddr2", 32'(out_raddr2), 32'(e.rs2));
    check("ren", 32'(out_ren), 32'(e.ren));
    check("wen", 32'(out_wen), 32'(e.wen));
    check("illegal", 32'(out_illegal), 32'(e.ill));
    check("ecall", 32'(out_ecall), 32'(e.ecall));
    check("ebreak", 32'(out_ebreak), 32'(e.ebreak));
  endtask

  // Monitor: compares handshakes and fields each cycle, then advances the model to the next edge.
  initial begin : monitor
    exp_t e;
    bit   ov, ir, iss;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        ov = stage_full && exp_q.size() > 0 && !hazard(exp_q[0]);
        ir = !flush && (!stage_full || (ov && out_ready));
        check("out_valid", 32'(out_valid), 32'(ov));
        check("in_ready", 32'(in_ready), 32'(ir));
        if (stage_full && out_valid && exp_q.size() > 0) cmp_fields(exp_q[0]);
        iss = ov && out_ready;
        if (iss) begin
          e = exp_q.pop_front();
          if (e.wen) pend[e.rd]++;
        end else if (stage_full && flush && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
        end
        if (wb_valid && wb_rd != 0 && pend[wb_rd] > 0) pend[wb_rd]--;
        if (in_valid && in_ready) stage_full = 1;
        else if (iss || flush)    stage_full = 0;
      end
    end
  end

  task automatic step(input bit gen, input bit dir, input int wb_div);
    int pr[$];
    @(negedge clk);
    pr = {};
    for (int r = 1; r < 32; r++) if (pend[r] > 0) pr.push_back(r);
    wb_valid = 1'b0;
    wb_rd    = 5'd0;
    if (pr.size() > 0 && $urandom_range(0, wb_div) == 0) begin
      wb_valid = 1'b1;
      wb_rd    = 5'(pr[$urandom_range(0, pr.size() - 1)]);
    end
    out_ready = (!gen || dir) ? 1'b1 : ($urandom_range(0, 3) != 0);
    flush     = 1'b0;
    if (!hold && gen) begin
      if (dir && dir_idx < NDIR) begin
        cur_inst = dir_list[dir_idx];
        dir_idx++;
        hold = 1;
      end else if (!dir && $urandom_range(0, 3) != 0) begin
        cur_inst = rand_inst();
        hold = 1;
      end
      if (hold) cur_pc = cur_pc + 32'd4;
    end
    in_valid = hold;
    in_inst  = hold ? cur_inst : $urandom;
    in_pc    = cur_pc;
    if (gen && !dir && !out_ready && $urandom_range(0, 11) == 0) flush = 1'b1;
    #1;
    if (in_valid && in_ready) begin
      exp_q.push_back(ref_decode(in_inst, in_pc, 32));
      hold = 0;
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin : main
    rst_n = 0; flush = 0; in_valid = 0; in_inst = 0; in_pc = 0; out_ready = 0; wb_valid = 0; wb_rd = 0;
    e_flush = 0; e_in_valid = 0; e_in_inst = 0; e_in_pc = 0; e_out_ready = 1; e_wb_valid = 0; e_wb_rd = 0;
    mon_en = 0; stage_full = 0; hold = 0; dir_idx = 0; cur_pc = 32'h8000_0000; cur_inst = 0;
    for (int r = 0; r < 32; r++) pend[r] = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_imm", out_imm, 32'd0);
    check("rst_out_wen", 32'(out_wen), 32'd0);
    check("rst_out_illegal", 32'(out_illegal), 32'd0);
    check("rst_e_out_valid", 32'(e_out_valid), 32'd0);

    // RV32E instance: out-of-range registers are illegal and never reach the scoreboard.
    @(negedge clk); e_in_valid = 1; e_in_inst = 32'h014100B3; e_in_pc = 32'h100;
    @(negedge clk); e_in_inst = 32'h00108133; e_in_pc = 32'h104;
    #2;
    check("e_ill_valid", 32'(e_out_valid), 32'd1);
    check("e_ill_flag", 32'(e_out_illegal), 32'd1);
    check("e_ill_wen", 32'(e_out_wen), 32'd0);
    check("e_ill_ren", 32'(e_out_ren), 32'd0);
    check("e_in_ready", 32'(e_in_ready), 32'd1);
    @(negedge clk); e_in_valid = 0;
    #2;
    check("e_add_valid", 32'(e_out_valid), 32'd1);
    check("e_add_illegal", 32'(e_out_illegal), 32'd0);
    check("e_add_wen", 32'(e_out_wen), 32'd1);
    check("e_add_rd", 32'(e_out_rd), 32'd2);
    check("e_add_ren", 32'(e_out_ren), 32'd3);

    mon_en = 1;
    for (int c = 0; c < 600 && (dir_idx < NDIR || hold); c++) step(1, 1, 9);
    for (int c = 0; c < 3000; c++) step(1, 0, 2);
    for (int c = 0; c < 400 && (exp_q.size() > 0 || hold || pend_any()); c++) step(0, 0, 1);
    #3;
    in_valid = 0; wb_valid = 0; flush = 0;
    check("drain_queue", 32'(exp_q.size()), 32'd0);
    check("drain_pending", 32'(pend_any()), 32'd0);

    // Reset while a dependent instruction is stalled: stage and counters are discarded.
    @(negedge clk); #1; mon_en = 0;
    @(negedge clk); in_valid = 1; in_inst = 32'h00500293; out_ready = 1;
    @(negedge clk); in_inst = 32'h00528333;
    @(negedge clk); in_valid = 0;
    #2;
    check("pre_rst_hazard", 32'(out_valid), 32'd0);
    check("pre_rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 0;
    @(negedge clk); rst_n = 1;
    #2;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); in_valid = 1; in_inst = 32'h00528333;
    @(negedge clk); in_valid = 0;
    #2;
    check("post_rst_no_hazard", 32'(out_valid), 32'd1);
    check("post_rst_rd", 32'(out_rd), 32'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
